// File: rtl/mem_handler.sv
// mem_handler: in-order request FIFO feeding a single-outstanding memory
// access FSM (IDLE/WRITE/READ/WAIT/RESP) with read timeout and response hold.
// Build option: define MEM_HANDLER_WRACK_EN to have each write return a
// response (rsp_write=1); by default writes are silent.
module mem_handler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  // client request
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  // client response
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_write,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  // memory side
  output logic [7:0] mem_address,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_raddress,
  input  logic [7:0] mem_rdata,
  input  logic       mem_oe
);

  localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  state_t        state_q;
  req_t          fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          push;
  logic          pop;
  req_t          head;

  logic [7:0]    wait_cnt_q;
  logic [7:0]    lat_addr_q;
  logic          mem_we_q;
  logic          mem_re_q;
  logic [7:0]    mem_address_q;
  logic [7:0]    mem_wdata_q;
  logic          rsp_valid_q;
  logic          rsp_write_q;
  logic [7:0]    rsp_addr_q;
  logic [7:0]    rsp_data_q;
  logic          rsp_err_q;

  assign req_ready = (count_q != DEPTH_C);

  // FIFO handshake decode and occupancy next-state
  always_comb begin
    push    = req_valid && req_ready;
    pop     = (state_q == IDLE) && (count_q != '0);
    head    = fifo_q[rd_ptr_q];
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // FIFO storage: payload needs no reset, validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Access FSM with registered memory strobes and response fields.
  // Memory strobes default to zero each cycle and are only raised on the
  // transition into WRITE/READ, so each is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      lat_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            lat_addr_q    <= head.addr;
            mem_address_q <= head.addr;
            if (head.write) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= head.wdata;
              state_q     <= WRITE;
            end else begin
              mem_re_q <= 1'b1;
              state_q  <= READ;
            end
          end
        end
        WRITE: begin
`ifdef MEM_HANDLER_WRACK_EN
          rsp_valid_q <= 1'b1;
          rsp_write_q <= 1'b1;
          rsp_addr_q  <= lat_addr_q;
          rsp_data_q  <= mem_wdata_q;
          rsp_err_q   <= 1'b0;
          state_q     <= RESP;
`else
          state_q <= IDLE;
`endif
        end
        READ: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (mem_oe && (mem_raddress == lat_addr_q)) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b0;
            rsp_addr_q  <= lat_addr_q;
            rsp_data_q  <= mem_rdata;
            rsp_err_q   <= 1'b0;
            state_q     <= RESP;
          end else if (wait_cnt_q == TMO_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b0;
            rsp_addr_q  <= lat_addr_q;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_mem_handler.sv
// tb_mem_handler: randomized + directed scoreboard bench for mem_handler.
// Follows MEM_HANDLER_WRACK_EN in the same way as the design.
`timescale 1ns/1ps
module tb_mem_handler;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [7:0] rsp_addr, rsp_data;
  logic [7:0] mem_address, mem_wdata, mem_raddress, mem_rdata;
  logic       mem_we, mem_re, mem_oe;

  mem_handler #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_raddress(mem_raddress), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    bit         e;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  int         mode_q[$];        // 0 normal, 1 mismatch x3 then match, 2 silent
  logic [7:0] ref_mem  [256];
  logic [7:0] phys_mem [256];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_mode  = 1;            // 0 random, 1 always ready, 2 stall 10 cycles
  int stall_cnt = 0;
  int resp_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_outputs"},
          32'({mem_we, mem_re, mem_address, mem_wdata, rsp_valid, rsp_write,
               rsp_addr, rsp_data, rsp_err}), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Memory responder: one-cycle latency by default, per-read mode from mode_q
  int         r_phase = -1;
  int         r_mode  = 0;
  logic [7:0] r_addr  = '0;
  initial begin
    mem_oe = 1'b0; mem_raddress = '0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_oe = 1'b0; mem_raddress = '0; mem_rdata = '0;
      if (r_phase >= 0) begin
        if (r_mode == 2) begin
          r_phase = -1;
        end else if (r_mode == 1 && r_phase < 3) begin
          mem_oe = 1'b1; mem_raddress = r_addr + 8'd1; mem_rdata = ~phys_mem[r_addr];
          r_phase++;
        end else begin
          mem_oe = 1'b1; mem_raddress = r_addr; mem_rdata = phys_mem[r_addr];
          r_phase = -1;
        end
      end
      if (!rst && mem_we) phys_mem[mem_address] = mem_wdata;
      if (!rst && mem_re) begin
        r_mode  = (mode_q.size() > 0) ? mode_q.pop_front() : 0;
        r_addr  = mem_address;
        r_phase = 0;
      end
    end
  end

  // Response-ready driver
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) rsp_ready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 2 && rsp_valid && stall_cnt < 10) begin
        rsp_ready = 1'b0;
        stall_cnt++;
      end else rsp_ready = 1'b1;
    end
  end

  // Monitor: bus rules every cycle, scoreboard pop on response handshake
  exp_t       e;
  bit         holding = 1'b0;
  logic [17:0] held = '0;
  bit         prev_we = 1'b0, prev_re = 1'b0;
  int         last_re = -100;
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0; prev_we = 1'b0; prev_re = 1'b0;
    end else begin
      check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
      if (!mem_we && !mem_re) check("idle_bus_zero", 32'({mem_address, mem_wdata}), 32'd0);
      check("strobe_one_cycle", 32'((mem_we & prev_we) | (mem_re & prev_re)), 32'd0);
      if (rsp_valid) check("no_mem_op_in_resp", 32'(mem_we | mem_re), 32'd0);
      if (rsp_valid) begin
        if (!holding) begin
          resp_seen++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rsp: got w=%0b a=0x%h d=0x%h e=%0b, none expected",
                     rsp_write, rsp_addr, rsp_data, rsp_err);
          end else begin
            e = exp_q[0];
            check("rsp_fields", 32'({rsp_write, rsp_addr, rsp_data, rsp_err}),
                  32'({e.w, e.a, e.d, e.e}));
            if (e.lat > 0) check("read_latency", 32'(cyc - last_re), 32'(e.lat));
          end
          held    = {rsp_write, rsp_addr, rsp_data, rsp_err};
          holding = 1'b1;
        end else begin
          check("rsp_stable", 32'({rsp_write, rsp_addr, rsp_data, rsp_err}), 32'(held));
        end
        if (rsp_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          holding = 1'b0;
        end
      end
      prev_we = mem_we;
      prev_re = mem_re;
      if (mem_re) last_re = cyc;
    end
  end

  // Issue one request and record its expected outcome once accepted
  task automatic send(input bit w, input logic [7:0] a, input logic [7:0] d, input int mode);
    exp_t x;
    int   b;
    bit   ok;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    b = 0; ok = 1'b0;
    while (b < 300) begin
      if (req_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      b++;
    end
    #1;
    req_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0, required 1 within 300 cycles");
    end else if (w) begin
      ref_mem[a] = d;
`ifdef MEM_HANDLER_WRACK_EN
      x.w = 1'b1; x.a = a; x.d = d; x.e = 1'b0; x.lat = 0;
      exp_q.push_back(x);
`endif
    end else begin
      mode_q.push_back(mode);
      x.w = 1'b0; x.a = a;
      if (mode == 2) begin
        x.d = 8'h00; x.e = 1'b1; x.lat = TMO + 1;
      end else begin
        x.d = ref_mem[a]; x.e = 1'b0; x.lat = (mode == 1) ? 5 : 2;
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || rsp_valid) && b < 1000) begin
      @(negedge clk);
      b++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  bit         rw;
  logic [7:0] ra, rd;
  int         rm, rr, seen0, b;
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = 8'(i) ^ 8'h5A;
      phys_mem[i] = 8'(i) ^ 8'h5A;
    end
    repeat (3) @(posedge clk);
    #2;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // write then read back the same address
    rdy_mode = 1;
    send(1'b1, 8'h10, 8'hA5, 0);
    send(1'b0, 8'h10, 8'h00, 0);
    drain();

    // five back-to-back reads: FIFO fills, order preserved
    for (int k = 1; k <= 5; k++) send(1'b0, 8'(k), 8'h00, 0);
    check("fifo_full_ready", 32'(req_ready), 32'd0);
    drain();

    // silent memory: timeout error
    send(1'b0, 8'h20, 8'h00, 2);
    drain();

    // mismatched read address ignored, then match
    send(1'b1, 8'h30, 8'h5C, 0);
    send(1'b0, 8'h30, 8'h00, 1);
    drain();

    // response held for 10 cycles with follow-on requests queued
    stall_cnt = 0;
    rdy_mode  = 2;
    send(1'b0, 8'h44, 8'h00, 0);
    send(1'b1, 8'h45, 8'h77, 0);
    send(1'b0, 8'h45, 8'h00, 0);
    drain();
    check("stall_cycles", 32'(stall_cnt), 32'd10);
    rdy_mode = 1;

    // reset during WAIT with two requests queued
    send(1'b0, 8'h50, 8'h00, 2);
    b = 0;
    while (!mem_re && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("reset_test_read_issued", 32'(mem_re), 32'd1);
    send(1'b0, 8'h51, 8'h00, 0);
    send(1'b0, 8'h52, 8'h00, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    mode_q.delete();
    r_phase = -1;
    seen0 = resp_seen;
    check_reset("mid_wait");
    @(posedge clk);
    #1;
    check_reset("mid_wait_next");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_rsp_after_reset", 32'(resp_seen - seen0), 32'd0);

    // randomized traffic
    rdy_mode = 0;
    for (int n = 0; n < 80; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 15));
      rd = 8'($urandom);
      rr = $urandom_range(0, 9);
      rm = (rr < 7) ? 0 : ((rr < 9) ? 1 : 2);
      send(rw, ra, rd, rm);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
